cla_operand_bus_driver: RTL and testbench



---
 rtl/cla_operand_bus_driver.sv | 181 ++++++++++++++++++
 tb/tb_cla_operand_bus_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_operand_bus_driver.sv
// Host-side transmitter for the time-multiplexed adder pin interface.
// Sequences operand A (captured on the pin_clk falling edge) and operand B
// (captured on the rising edge) over a shared bus, waits a settle period,
// then samples the DUT sum/carry pins and flags any mismatch against a+b.
module cla_operand_bus_driver #(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned HALF   = 2,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             pin_clk,
  output logic [WIDTH-1:0] pin_bus,
  input  logic [WIDTH-1:0] pin_sum,
  input  logic             pin_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_A_PH = 3'd1;
  localparam logic [2:0] S_FALL = 3'd2;
  localparam logic [2:0] S_B_PH = 3'd3;
  localparam logic [2:0] S_RISE = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [3:0] HALF_M1   = 4'(HALF - 1);
  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic             pin_clk_q, pin_clk_d;
  logic [WIDTH-1:0] pin_bus_q, pin_bus_d;
  logic             op_ready_q, op_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_carry_q, res_carry_d;
  logic             res_err_q, res_err_d;

  logic [WIDTH:0]   sum_ab;

  assign sum_ab = {1'b0, a_q} + {1'b0, b_q};

  // Next-state, phase counter, operand latch and result capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    res_sum_d   = res_sum_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid && op_ready_q) begin
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_A_PH;
          cnt_d   = HALF_M1;
        end
      end
      S_A_PH: begin
        if (cnt_q == '0) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_FALL: begin
        state_d = S_B_PH;
        cnt_d   = HALF_M1;
      end
      S_B_PH: begin
        if (cnt_q == '0) begin
          state_d = S_RISE;
          cnt_d   = SETTLE_M1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RISE: begin
        if (cnt_q == '0) begin
          state_d     = S_RESP;
          cnt_d       = '0;
          res_sum_d   = pin_sum;
          res_carry_d = pin_carry;
          res_err_d   = ({pin_carry, pin_sum} != sum_ab);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin and handshake outputs decoded from the next state so they register
  // in lockstep with the state; bus and clock transitions fall on different
  // state entries, so they never change in the same cycle.
  always_comb begin
    pin_clk_d   = 1'b1;
    pin_bus_d   = '0;
    op_ready_d  = 1'b0;
    res_valid_d = 1'b0;
    case (state_d)
      S_IDLE: op_ready_d = 1'b1;
      S_A_PH: pin_bus_d  = a_d;
      S_FALL: begin
        pin_clk_d = 1'b0;
        pin_bus_d = a_d;
      end
      S_B_PH: begin
        pin_clk_d = 1'b0;
        pin_bus_d = b_d;
      end
      S_RISE: pin_bus_d = b_d;
      S_RESP: begin
        pin_bus_d   = b_d;
        res_valid_d = 1'b1;
      end
      default: op_ready_d = 1'b1;
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pin_clk_q   <= 1'b1;
      pin_bus_q   <= '0;
      op_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pin_clk_q   <= pin_clk_d;
      pin_bus_q   <= pin_bus_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
    end
  end

  assign pin_clk   = pin_clk_q;
  assign pin_bus   = pin_bus_q;
  assign op_ready  = op_ready_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_cla_operand_bus_driver.sv
// Bench for cla_operand_bus_driver: a default build and a HALF=1/SETTLE=1
// build, each attached to a behavioural model of the adder chip.
module tb_cla_operand_bus_driver;

  localparam int W   = 7;
  localparam int H   = 2;
  localparam int S   = 4;
  localparam int LAT = 2 * H + 1 + S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   fails  = 0;

  // ---------------- default build ----------------
  logic         op_valid, op_ready, pin_clk, pin_carry;
  logic [W-1:0] op_a, op_b, pin_bus, pin_sum;
  logic         res_valid, res_ready, res_carry, res_err;
  logic [W-1:0] res_sum;

  cla_operand_bus_driver #(.WIDTH(W), .HALF(H), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pin_clk(pin_clk), .pin_bus(pin_bus), .pin_sum(pin_sum), .pin_carry(pin_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_carry(res_carry), .res_err(res_err)
  );

  // Chip model: A latched on the falling pin edge, B on the rising edge,
  // combinational sum plus an injectable error offset.
  logic [W-1:0] chip_a = '0, chip_b = '0;
  logic [W:0]   fault  = '0;
  always @(negedge pin_clk) chip_a = pin_bus;
  always @(posedge pin_clk) chip_b = pin_bus;
  assign {pin_carry, pin_sum} = {1'b0, chip_a} + {1'b0, chip_b} + fault;

  // ---------------- fast build ----------------
  logic         op_valid_f, op_ready_f, pin_clk_f, pin_carry_f;
  logic [W-1:0] op_a_f, op_b_f, pin_bus_f, pin_sum_f;
  logic         res_valid_f, res_ready_f, res_carry_f, res_err_f;
  logic [W-1:0] res_sum_f;

  cla_operand_bus_driver #(.WIDTH(W), .HALF(1), .SETTLE(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid_f), .op_ready(op_ready_f), .op_a(op_a_f), .op_b(op_b_f),
    .pin_clk(pin_clk_f), .pin_bus(pin_bus_f), .pin_sum(pin_sum_f), .pin_carry(pin_carry_f),
    .res_valid(res_valid_f), .res_ready(res_ready_f), .res_sum(res_sum_f),
    .res_carry(res_carry_f), .res_err(res_err_f)
  );

  logic [W-1:0] chip_a_f = '0, chip_b_f = '0;
  always @(negedge pin_clk_f) chip_a_f = pin_bus_f;
  always @(posedge pin_clk_f) chip_b_f = pin_bus_f;
  assign {pin_carry_f, pin_sum_f} = {1'b0, chip_a_f} + {1'b0, chip_b_f};

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    op_valid_f = 1'b0; op_a_f = '0; op_b_f = '0; res_ready_f = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (pin_clk !== 1'b1)   begin fails++; $display("FAIL reset_pin_clk got %b want 1", pin_clk); end
    checks++; if (pin_bus !== '0)     begin fails++; $display("FAIL reset_pin_bus got %h want 0", pin_bus); end
    checks++; if (op_ready !== 1'b1)  begin fails++; $display("FAIL reset_op_ready got %b want 1", op_ready); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if ({res_carry, res_sum, res_err} !== '0) begin
      fails++; $display("FAIL reset_result got %b%h%b want 0", res_carry, res_sum, res_err);
    end
    checks++; if (pin_clk_f !== 1'b1 || op_ready_f !== 1'b1 || res_valid_f !== 1'b0) begin
      fails++; $display("FAIL reset_fast got clk=%b rdy=%b vld=%b want 1 1 0", pin_clk_f, op_ready_f, res_valid_f);
    end
  endtask

  // Starts a transaction on the default build; returns on the first negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] flt);
    int n;
    fault = flt;
    n = 0;
    while (op_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (op_ready !== 1'b1) begin fails++; $display("FAIL op_ready_wait got %b want 1", op_ready); end
    op_a = a; op_b = b; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
  endtask

  // Full transaction with pin-waveform, latency, result, stall and release checks.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] flt, input int stall);
    logic [W:0] ideal, want;
    logic       exp_clk;
    logic [W-1:0] exp_bus;
    start_op(a, b, flt);
    for (int k = 0; k <= LAT; k++) begin
      exp_clk = (k < H || k > 2 * H) ? 1'b1 : 1'b0;
      exp_bus = (k <= H) ? a : b;
      checks++; if (res_valid !== (k == LAT)) begin fails++; $display("FAIL latency k=%0d res_valid got %b want %b", k, res_valid, k == LAT); end
      checks++; if (pin_clk !== exp_clk) begin fails++; $display("FAIL pin_clk_seq k=%0d got %b want %b", k, pin_clk, exp_clk); end
      checks++; if (pin_bus !== exp_bus) begin fails++; $display("FAIL pin_bus_seq k=%0d got %h want %h", k, pin_bus, exp_bus); end
      if (k < LAT) @(negedge clk);
    end
    ideal = {1'b0, a} + {1'b0, b};
    want  = ideal + flt;
    checks++; if (res_sum !== want[W-1:0]) begin fails++; $display("FAIL res_sum a=%h b=%h got %h want %h", a, b, res_sum, want[W-1:0]); end
    checks++; if (res_carry !== want[W]) begin fails++; $display("FAIL res_carry a=%h b=%h got %b want %b", a, b, res_carry, want[W]); end
    checks++; if (res_err !== (want != ideal)) begin fails++; $display("FAIL res_err a=%h b=%h got %b want %b", a, b, res_err, want != ideal); end
    for (int s = 0; s < stall; s++) begin
      op_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || op_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hs s=%0d got vld=%b rdy=%b want 1 0", s, res_valid, op_ready);
      end
      checks++; if ({res_carry, res_sum} !== want) begin fails++; $display("FAIL stall_result s=%0d got %h want %h", s, {res_carry, res_sum}, want); end
      checks++; if (pin_clk !== 1'b1 || pin_bus !== b) begin
        fails++; $display("FAIL stall_pins s=%0d got clk=%b bus=%h want 1 %h", s, pin_clk, pin_bus, b);
      end
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      fails++; $display("FAIL release got vld=%b rdy=%b want 0 1", res_valid, op_ready);
    end
    checks++; if (pin_bus !== '0 || pin_clk !== 1'b1) begin
      fails++; $display("FAIL release_pins got clk=%b bus=%h want 1 0", pin_clk, pin_bus);
    end
  endtask

  task automatic test_basic;
    run_op(7'd5, 7'd3, '0, 0);
  endtask

  task automatic test_carry;
    run_op(7'h7F, 7'h01, '0, 0);
    run_op(7'h7F, 7'h7F, '0, 0);
    for (int i = 0; i < 4; i++) run_op(W'($urandom), W'($urandom), '0, 0);
  endtask

  task automatic test_fault;
    run_op(7'd10, 7'd20, 8'd1, 0);
    fault = '0;
  endtask

  task automatic test_stall;
    run_op(W'($urandom), W'($urandom), '0, 20);
  endtask

  task automatic test_reset_mid;
    start_op(7'h2A, 7'h15, '0);
    repeat (H + 1) @(negedge clk);
    checks++; if (pin_clk !== 1'b0 || pin_bus !== 7'h15) begin
      fails++; $display("FAIL mid_bph got clk=%b bus=%h want 0 15", pin_clk, pin_bus);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (pin_clk !== 1'b1 || pin_bus !== '0) begin
      fails++; $display("FAIL mid_reset_pins got clk=%b bus=%h want 1 0", pin_clk, pin_bus);
    end
    checks++; if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_hs got vld=%b rdy=%b want 0 1", res_valid, op_ready);
    end
    run_op(7'd33, 7'd44, '0, 0);
  endtask

  task automatic test_back_to_back;
    logic [W:0]   q[$];
    logic [W:0]   want;
    logic         prev_clk;
    logic [W-1:0] prev_bus;
    int issued, got, cyc;
    issued = 0; got = 0; cyc = 0;
    res_ready_f = 1'b1;
    prev_clk = pin_clk_f; prev_bus = pin_bus_f;
    while (got < 100 && cyc < 3000) begin
      if (res_valid_f === 1'b1) begin
        if (q.size() == 0) begin
          checks++; fails++; $display("FAIL b2b_unexpected got %h want none", {res_carry_f, res_sum_f});
        end else begin
          want = q.pop_front();
          checks++; if ({res_carry_f, res_sum_f} !== want) begin
            fails++; $display("FAIL b2b_result n=%0d got %h want %h", got, {res_carry_f, res_sum_f}, want);
          end
          checks++; if (res_err_f !== 1'b0) begin fails++; $display("FAIL b2b_err n=%0d got %b want 0", got, res_err_f); end
        end
        got++;
      end
      if (op_ready_f === 1'b1 && issued < 100) begin
        op_a_f = W'($urandom); op_b_f = W'($urandom); op_valid_f = 1'b1;
        q.push_back({1'b0, op_a_f} + {1'b0, op_b_f});
        issued++;
      end else begin
        op_valid_f = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (pin_clk_f !== prev_clk) begin
        checks++; if (pin_bus_f !== prev_bus) begin
          fails++; $display("FAIL edge_bus_change cyc=%0d got bus %h->%h want no change", cyc, prev_bus, pin_bus_f);
        end
      end
      prev_clk = pin_clk_f; prev_bus = pin_bus_f;
    end
    op_valid_f = 1'b0;
    checks++; if (got != 100) begin fails++; $display("FAIL b2b_count got %0d want 100", got); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_fault;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
